// File: rtl/huffman_pkg.sv
// Shared Huffman code table and encoder state encoding.
// The decoder imports the same table, so edit both ends together.
package huffman_pkg;

  localparam int MAX_LEN = 6;

  // Codes are left-aligned in 6 bits; the unused LSBs are zero.
  localparam logic [15:0][5:0] CODE_TAB = {
    6'b000101, 6'b000100, 6'b000000, 6'b000111,
    6'b000000, 6'b000000, 6'b011100, 6'b000110,
    6'b011010, 6'b001100, 6'b001000, 6'b011001,
    6'b011000, 6'b010100, 6'b010000, 6'b100000
  };

  localparam logic [15:0][2:0] LEN_TAB = {
    3'd6, 3'd6, 3'd0, 3'd6,
    3'd0, 3'd4, 3'd4, 3'd6,
    3'd5, 3'd4, 3'd4, 3'd6,
    3'd6, 3'd4, 3'd4, 3'd1
  };

  // Symbols 11 and 13 have no code.
  localparam logic [15:0] VALID_TAB = 16'hD7FF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/huffman_code_lut.sv
// Combinational symbol-to-code lookup: left-aligned code, length, codable flag.
module huffman_code_lut
  import huffman_pkg::*;
(
  input  logic [3:0] in_sym,
  output logic [5:0] code,
  output logic [2:0] len,
  output logic       valid
);

  assign code  = CODE_TAB[in_sym];
  assign len   = LEN_TAB[in_sym];
  assign valid = VALID_TAB[in_sym];

endmodule

// File: rtl/huffman_encoder.sv
// Streaming Huffman encoder packing prefix codes MSB-first into OUT_W-bit words.
// A flush drains the accumulator and tags the final word with its valid-bit count.
module huffman_encoder
  import huffman_pkg::*;
#(
  parameter int OUT_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_sym,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_nbits,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  localparam int ACC_W = OUT_W + MAX_LEN - 1;
  localparam int OCC_W = $clog2(ACC_W + 1);
  localparam logic [OCC_W-1:0] OUT_W_C = OCC_W'(OUT_W);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [OCC_W-1:0] cnt;
  logic [5:0]       code;
  logic [2:0]       len;
  logic             code_ok;
  logic             push;
  logic             pop;
  logic [ACC_W-1:0] code_wide;

  huffman_code_lut u_lut (
    .in_sym (in_sym),
    .code   (code),
    .len    (len),
    .valid  (code_ok)
  );

  // All handshake outputs derive from registered state only, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state == RUN) && (cnt < OUT_W_C);
  assign out_valid = (state == RUN)   ? (cnt >= OUT_W_C)
                   : (state == FLUSH) ? (cnt != '0)
                   : 1'b0;
  assign out_last  = (state == FLUSH) && (cnt != '0) && (cnt <= OUT_W_C);
  assign out_nbits = !out_valid        ? 3'd0
                   : (cnt >= OUT_W_C)  ? 3'(OUT_W)
                   : 3'(cnt);
  // Bits below cnt are kept zero, so the final word is already zero-padded.
  assign out_data  = out_valid ? acc[ACC_W-1 -: OUT_W] : '0;
  assign done      = (state == DONE);

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign code_wide = {code, {(ACC_W - MAX_LEN){1'b0}}} >> cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush) state_next = FLUSH;
      FLUSH:   if ((cnt == '0) || (pop && out_last)) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Push and pop never coincide: in_ready and out_valid are disjoint in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      bit_count <= '0;
      err       <= 1'b0;
    end else begin
      err <= push && !code_ok;
      if (state == DONE) begin
        acc <= '0;
        cnt <= '0;
      end else if (push && code_ok) begin
        acc       <= acc | code_wide;
        cnt       <= cnt + OCC_W'(len);
        bit_count <= bit_count + CNT_W'(len);
      end else if (pop) begin
        acc <= acc << OUT_W;
        cnt <= (cnt >= OUT_W_C) ? (cnt - OUT_W_C) : '0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed-vector bench for huffman_encoder with hand-computed expectations.
module tb_huffman_encoder;
  import huffman_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_sym = 4'd0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [5:0]  out_data;
  logic [2:0]  out_nbits;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        err;
  logic        done;
  logic [15:0] bit_count;

  int errors = 0;
  int checks = 0;

  huffman_encoder #(.OUT_W(6), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err       (err),
    .done      (done),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Offer one symbol and return at the negedge after its handshake.
  task automatic send(input logic [3:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_sym = s;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Accept one word, checking its contents before the handshake edge.
  task automatic recv(input string tag, input logic [5:0] data,
                      input logic [2:0] nbits, input logic last);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(data));
    check({tag, "_nbits"}, 32'(out_nbits), 32'(nbits));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    // Reset state
    apply_reset();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    check("rst_out_nbits", 32'(out_nbits), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Six single-bit codes fill exactly one word
    for (int i = 0; i < 6; i++) send(4'd0);
    check("s0_in_ready", 32'(in_ready), 32'd0);
    check("s0_bit_count", 32'(bit_count), 32'd6);
    recv("s0_w", 6'b111111, 3'd6, 1'b0);
    check("s0_empty", 32'(out_valid), 32'd0);

    // 0111 + 011000 then flush: one full word plus a 4-bit tail
    apply_reset();
    send(4'd9);
    send(4'd3);
    pulse_flush();
    check("fl_in_ready", 32'(in_ready), 32'd0);
    recv("fl_w1", 6'b011101, 3'd6, 1'b0);
    recv("fl_w2", 6'b100000, 3'd4, 1'b1);
    check("fl_done", 32'(done), 32'd1);
    check("fl_bit_count", 32'(bit_count), 32'd10);
    @(negedge clk);
    check("fl_done_pulse", 32'(done), 32'd0);
    check("fl_back_run", 32'(in_ready), 32'd1);

    // Six 5-bit codes straddle word boundaries and end exactly aligned
    apply_reset();
    send(4'd7);
    send(4'd7);
    recv("s7_w1", 6'b011010, 3'd6, 1'b0);
    send(4'd7);
    recv("s7_w2", 6'b110101, 3'd6, 1'b0);
    send(4'd7);
    recv("s7_w3", 6'b101011, 3'd6, 1'b0);
    send(4'd7);
    recv("s7_w4", 6'b010110, 3'd6, 1'b0);
    send(4'd7);
    recv("s7_w5", 6'b101101, 3'd6, 1'b0);
    check("s7_cnt", 32'(dut.cnt), 32'd0);
    check("s7_bit_count", 32'(bit_count), 32'd30);
    pulse_flush();
    check("s7_flush_noword", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("s7_done", 32'(done), 32'd1);
    @(negedge clk);
    check("s7_done_pulse", 32'(done), 32'd0);

    // Uncodable symbols raise err and contribute no bits
    apply_reset();
    send(4'd11);
    check("u11_err", 32'(err), 32'd1);
    send(4'd13);
    check("u13_err", 32'(err), 32'd1);
    @(negedge clk);
    check("u_err_pulse", 32'(err), 32'd0);
    check("u_bit_count", 32'(bit_count), 32'd0);
    check("u_out_valid", 32'(out_valid), 32'd0);
    send(4'd0);
    pulse_flush();
    recv("u_tail", 6'b100000, 3'd1, 1'b1);
    check("u_done", 32'(done), 32'd1);

    // Backpressure holds the word; reset mid-flush discards everything
    apply_reset();
    send(4'd3);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data", 32'(out_data), 32'(6'b011000));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data", 32'(out_data), 32'(6'b011000));
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    recv("bp_w1", 6'b011000, 3'd6, 1'b0);
    send(4'd4);
    recv("bp_w2", 6'b011001, 3'd6, 1'b0);
    send(4'd0);
    pulse_flush();
    check("rf_flush_valid", 32'(out_valid), 32'd1);
    check("rf_flush_last", 32'(out_last), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rf_out_valid", 32'(out_valid), 32'd0);
    check("rf_in_ready", 32'(in_ready), 32'd1);
    check("rf_state", 32'(dut.state), 32'(RUN));
    check("rf_cnt", 32'(dut.cnt), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rf_no_word", 32'(out_valid), 32'd0);
    check("rf_no_done", 32'(done), 32'd0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
